// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: data width, divider state encoding, magnitude helper.
package coproc_pkg;

  localparam int unsigned DATA_W = 8;

  // Wide enough to take any supported operand width after sign extension.
  localparam int unsigned ABS_W = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Unsigned magnitude of a sign-extended operand; |MIN| of the narrow type fits.
  function automatic logic [ABS_W-1:0] abs_u(input logic signed [ABS_W-1:0] x);
    return x[ABS_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] prem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Extra top bit carries the sign of the trial subtraction.
  always_comb begin
    shifted   = {prem, dvd_msb};
    trial     = shifted - {1'b0, dvs};
    qbit      = ~trial[WIDTH];
    prem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: one quotient bit per clock, truncating toward zero,
// remainder follows the dividend's sign. start/busy/done handshake.
module seq_divider
  import coproc_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] dvd_q;   // |dividend|, shifted out MSB-first while quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [CW-1:0]    cnt_q;
  logic             sgn_dvd_q, sgn_dvs_q;
  logic             done_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] prem_next;
  logic             qbit;
  logic             fix_dbz, fix_neg_q;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic             ovf_d;

  assign dvd_abs = WIDTH'(abs_u(ABS_W'($signed(dividend))));
  assign dvs_abs = WIDTH'(abs_u(ABS_W'($signed(divisor))));

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem     (prem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .dvs      (dvs_q),
    .prem_next(prem_next),
    .qbit     (qbit)
  );

  // Sign fix-up of the magnitudes; a zero divisor passes the dividend through as remainder.
  always_comb begin
    fix_dbz   = (dvs_q == '0);
    fix_neg_q = sgn_dvd_q ^ sgn_dvs_q;
    q_mag     = fix_dbz ? '0 : dvd_q;
    r_mag     = fix_dbz ? dvd_q : prem_q;
    quot_d    = fix_neg_q ? -q_mag : q_mag;
    rem_d     = sgn_dvd_q ? -r_mag : r_mag;
    // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
    ovf_d     = ~fix_dbz & ~fix_neg_q & dvd_q[WIDTH-1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start) state_d = (divisor == '0) ? DIV_FIX : DIV_CALC;
      DIV_CALC: if (cnt_q == LastStep) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q != DIV_IDLE);
    done = done_q;
    quot = quot_q;
    rem  = rem_q;
    dbz  = dbz_q;
    ovf  = ovf_q;
  end

  // Datapath: operand capture, restoring iterations, result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      sgn_dvd_q <= 1'b0;
      sgn_dvs_q <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            dvd_q     <= dvd_abs;
            dvs_q     <= dvs_abs;
            sgn_dvd_q <= dividend[WIDTH-1];
            sgn_dvs_q <= divisor[WIDTH-1];
            prem_q    <= '0;
            cnt_q     <= '0;
          end
        end
        DIV_CALC: begin
          prem_q <= prem_next;
          dvd_q  <= {dvd_q[WIDTH-2:0], qbit};
          cnt_q  <= cnt_q + CW'(1);
        end
        DIV_FIX: begin
          quot_q    <= quot_d;
          rem_q     <= rem_d;
          dbz_q     <= fix_dbz;
          ovf_q     <= ovf_d;
          done_q    <= 1'b1;
          dvd_q     <= '0;
          dvs_q     <= '0;
          prem_q    <= '0;
          cnt_q     <= '0;
          sgn_dvd_q <= 1'b0;
          sgn_dvs_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus random operands against an arithmetic model.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, dbz, ovf;
  logic [W-1:0] quot, rem;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .quot    (quot),
    .rem     (rem),
    .dbz     (dbz),
    .ovf     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (truncating), plus the two special cases.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output logic o, output int lat);
    int a, b;
    a   = int'($signed(av));
    b   = int'($signed(bv));
    z   = 1'b0;
    o   = 1'b0;
    lat = W + 1;
    if (b == 0) begin
      q = '0; r = av; z = 1'b1; lat = 1;
    end else if (a == -(2 ** (W - 1)) && b == -1) begin
      q = W'(-a); r = '0; o = 1'b1;
    end else begin
      q = W'(a / b); r = W'(a % b);
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; optionally pulses a stray start (9/3) before edge inj.
  task automatic wait_done(input string tag, input int exp_lat, input int inj);
    bit seen = 0;
    int lat  = 0;
    for (int n = 1; n <= 3 * W && !seen; n++) begin
      if (n == inj) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      end else if (n == inj + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        seen = 1; lat = n;
      end else begin
        check({tag, " busy"}, busy, 1);
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy@done"}, busy, 0);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input logic eo);
    check({tag, " quot"}, quot, eq);
    check({tag, " rem"}, rem, er);
    check({tag, " dbz"}, dbz, ez);
    check({tag, " ovf"}, ovf, eo);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez, eo;
    int           el;
    model(a, b, eq, er, ez, eo, el);
    launch(a, b);
    wait_done(tag, el, 0);
    check_res(tag, eq, er, ez, eo);
  endtask

  initial begin
    logic [W-1:0] eq, er, a, b;
    logic         ez, eo;
    int           el;
    bit           stray;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check_res("reset", 8'd0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic case and pulse width.
    run_op("7/2", 8'd7, 8'd2);
    check_res("7/2 const", 8'd3, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("7/2 done pulse", done, 0);

    // Sign combinations.
    run_op("-7/2", 8'hF9, 8'd2);
    check_res("-7/2 const", 8'hFD, 8'hFF, 1'b0, 1'b0);
    run_op("7/-2", 8'd7, 8'hFE);
    check_res("7/-2 const", 8'hFD, 8'd1, 1'b0, 1'b0);
    run_op("-7/-2", 8'hF9, 8'hFE);
    check_res("-7/-2 const", 8'd3, 8'hFF, 1'b0, 1'b0);
    run_op("127/1", 8'd127, 8'd1);

    // Overflow, then flag cleared.
    run_op("-128/-1", 8'h80, 8'hFF);
    check_res("-128/-1 const", 8'h80, 8'd0, 1'b0, 1'b1);
    run_op("-128/1", 8'h80, 8'd1);

    // Divide by zero, then flag cleared.
    run_op("5/0", 8'd5, 8'd0);
    check_res("5/0 const", 8'd0, 8'd5, 1'b1, 1'b0);
    run_op("6/3", 8'd6, 8'd3);

    // Stray start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    launch(8'd100, 8'd7);
    wait_done("100/7", W + 1, 4);
    check_res("100/7", 8'd14, 8'd2, 1'b0, 1'b0);
    model(8'd20, 8'hFD, eq, er, ez, eo, el);
    launch(8'd20, 8'hFD);
    check("b2b done low", done, 0);
    check("b2b busy", busy, 1);
    wait_done("20/-3", el, 0);
    check_res("20/-3", eq, er, ez, eo);

    // Random operands with a bias toward the special cases.
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = W'($urandom_range(0, 2)) - 8'd1;
        default: ;
      endcase
      run_op("rand", a, b);
    end

    // Reset mid-operation aborts with no done.
    run_op("-7/0", 8'hF9, 8'd0);
    launch(8'd50, 8'd5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check_res("midrst", 8'd0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    stray = 0;
    repeat (3 * W) begin
      @(negedge clk);
      if (done) stray = 1;
    end
    check("midrst no done", stray, 0);

    // Reset beats start.
    rst = 1'b1; start = 1'b1; dividend = 8'd7; divisor = 8'd2;
    @(negedge clk);
    check("rst+start busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst+start idle", busy, 0);
    check("rst+start done", done, 0);

    run_op("after rst", 8'd9, 8'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
